// File: rtl/vecmul_lane_scheduler_if.sv
// Request, response and lane-operand bundle between requesting engines, the scheduler and its lanes.
interface vecmul_lane_scheduler_if #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_LANES = 3,
  parameter int ELEM_W    = 8
);
  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ-1:0]                  req_ready;
  logic [NUM_REQ*4*ELEM_W-1:0]         req_a;
  logic [NUM_REQ*4*ELEM_W-1:0]         req_b;
  logic [NUM_REQ-1:0]                  rsp_valid;
  logic [NUM_REQ-1:0]                  rsp_ready;
  logic [NUM_REQ*4*(ELEM_W+1)-1:0]     rsp_data;
  logic [NUM_LANES*4*ELEM_W-1:0]       lane_a;
  logic [NUM_LANES*4*ELEM_W-1:0]       lane_b;
  logic [NUM_LANES*4*(ELEM_W+1)-1:0]   lane_c;

  modport master (
    output req_valid, req_a, req_b, rsp_ready, lane_c,
    input  req_ready, rsp_valid, rsp_data, lane_a, lane_b
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, lane_c,
    output req_ready, rsp_valid, rsp_data, lane_a, lane_b
  );
endinterface

// File: rtl/vecmul_lane_scheduler.sv
// Round-robin sharing of NUM_LANES vector-multiply lanes among NUM_REQ requesters.
// Handshakes: a transfer happens on a rising edge where valid & ready are both 1; valid never waits on ready.
module vecmul_lane_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_LANES = 3,
  parameter int LANE_LAT  = 1,
  parameter int ELEM_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  vecmul_lane_scheduler_if.slave bus,
  output logic                   busy,
  output logic [2*NUM_LANES-1:0] lane_state_dbg
);
  localparam int AW    = 4 * ELEM_W;
  localparam int CW    = 4 * (ELEM_W + 1);
  localparam int RW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LW    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CNT_W = (LANE_LAT > 1) ? $clog2(LANE_LAT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} lane_state_t;

  lane_state_t        state_q [NUM_LANES];
  lane_state_t        state_d [NUM_LANES];
  logic [RW-1:0]      owner_q [NUM_LANES];
  logic [CNT_W-1:0]   count_q [NUM_LANES];
  logic [AW-1:0]      a_q     [NUM_LANES];
  logic [AW-1:0]      b_q     [NUM_LANES];
  logic [CW-1:0]      res_q   [NUM_LANES];
  logic [RW-1:0]      rr_q;

  logic [NUM_REQ-1:0] has_job;
  logic [NUM_REQ-1:0] eligible;
  logic               idle_found;
  logic [LW-1:0]      target;
  logic               win_found;
  logic [RW-1:0]      winner;
  logic               accept;

  // Arbitration works only on registered lane state, so a lane freed this cycle is not reused.
  always_comb begin
    has_job = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (state_q[l] != IDLE) has_job[owner_q[l]] = 1'b1;
    end
    eligible = bus.req_valid & ~has_job;

    idle_found = 1'b0;
    target     = '0;
    for (int l = NUM_LANES - 1; l >= 0; l--) begin
      if (state_q[l] == IDLE) begin
        idle_found = 1'b1;
        target     = LW'(l);
      end
    end

    win_found = 1'b0;
    winner    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (eligible[(int'(rr_q) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        winner    = RW'((int'(rr_q) + k) % NUM_REQ);
      end
    end

    // Gating with rst_n keeps req_ready low while reset is held.
    accept        = win_found & idle_found & rst_n;
    bus.req_ready = '0;
    if (accept) bus.req_ready[winner] = 1'b1;
  end

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      state_d[l] = state_q[l];
      case (state_q[l])
        IDLE:    if (accept && target == LW'(l)) state_d[l] = RUN;
        RUN:     if (count_q[l] == CNT_W'(LANE_LAT - 1)) state_d[l] = DONE;
        DONE:    if (bus.rsp_ready[owner_q[l]]) state_d[l] = IDLE;
        default: state_d[l] = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.rsp_valid  = '0;
    bus.rsp_data   = '0;
    bus.lane_a     = '0;
    bus.lane_b     = '0;
    lane_state_dbg = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      bus.lane_a[l*AW +: AW]     = a_q[l];
      bus.lane_b[l*AW +: AW]     = b_q[l];
      lane_state_dbg[2*l +: 2]   = state_q[l];
      if (state_q[l] == DONE) begin
        bus.rsp_valid[owner_q[l]]               = 1'b1;
        bus.rsp_data[int'(owner_q[l])*CW +: CW] = res_q[l];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        state_q[l] <= IDLE;
        owner_q[l] <= '0;
        count_q[l] <= '0;
        a_q[l]     <= '0;
        b_q[l]     <= '0;
        res_q[l]   <= '0;
      end
      rr_q <= '0;
      busy <= 1'b0;
    end else begin
      busy <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) begin
        state_q[l] <= state_d[l];
        if (state_d[l] != IDLE) busy <= 1'b1;
        if (state_q[l] == IDLE && state_d[l] == RUN) begin
          a_q[l]     <= bus.req_a[int'(winner)*AW +: AW];
          b_q[l]     <= bus.req_b[int'(winner)*AW +: AW];
          owner_q[l] <= winner;
          count_q[l] <= '0;
        end
        if (state_q[l] == RUN) begin
          count_q[l] <= count_q[l] + 1'b1;
          if (state_d[l] == DONE) res_q[l] <= bus.lane_c[l*CW +: CW];
        end
      end
      if (accept) rr_q <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
    end
  end
endmodule
